// File: rtl/alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// alu_share_ctrl
//  Shares one combinational ALU between two requesters (e.g. EX stage and the
//  branch-compare unit). Round-robin arbitration with a valid/ready handshake
//  per requester, registered ALU operands held for EXEC_CYCLES cycles, and a
//  single response bus tagged with the owning requester id.
//
//  Optional feature macro: ALU_ILLEGAL_OP_EN
//    defined   : illegal opcodes are accepted, skip EXEC, and respond with
//                Resp_Out=0, Resp_Zero=0, Resp_Err=1 one cycle after accept.
//    undefined : every opcode goes to the ALU unchanged, Resp_Err tied to 0.
//
//  Ports
//    Clk, Reset               clock (rising edge), async active-high reset
//    ReqN_Valid/A/B/Op        requester N operation (N = 0, 1)
//    ReqN_Ready               requester N accepted this cycle (combinational)
//    Alu_A/Alu_B/Alu_Op       registered operands to the shared ALU
//    Alu_Out/Alu_Zero         results from the shared ALU
//    Resp_Valid/Id/Out/Zero/Err, Resp_Ready   response handshake
//    Busy                     controller not idle
// ----------------------------------------------------------------------------
module alu_share_ctrl #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned OP_W        = 4,
   parameter int unsigned EXEC_CYCLES = 1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Req0_Valid,
   input  logic [WIDTH-1:0] Req0_A,
   input  logic [WIDTH-1:0] Req0_B,
   input  logic [OP_W-1:0]  Req0_Op,
   output logic             Req0_Ready,
   input  logic             Req1_Valid,
   input  logic [WIDTH-1:0] Req1_A,
   input  logic [WIDTH-1:0] Req1_B,
   input  logic [OP_W-1:0]  Req1_Op,
   output logic             Req1_Ready,
   output logic [WIDTH-1:0] Alu_A,
   output logic [WIDTH-1:0] Alu_B,
   output logic [OP_W-1:0]  Alu_Op,
   input  logic [WIDTH-1:0] Alu_Out,
   input  logic             Alu_Zero,
   output logic             Resp_Valid,
   output logic             Resp_Id,
   output logic [WIDTH-1:0] Resp_Out,
   output logic             Resp_Zero,
   output logic             Resp_Err,
   input  logic             Resp_Ready,
   output logic             Busy
);

   localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               r_last_grant;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;

   logic               w_grant_vld;
   logic               w_grant_id;
   logic               w_accept;
   logic               w_illegal;
   logic [WIDTH-1:0]   w_sel_a;
   logic [WIDTH-1:0]   w_sel_b;
   logic [OP_W-1:0]    w_sel_op;

   // Round-robin grant: a lone requester wins; on a tie the one not granted last.
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_id  = 1'b0;
      if (r_state == S_IDLE) begin
         if (Req0_Valid && Req1_Valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_grant;
         end else if (Req0_Valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
         end else if (Req1_Valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
         end
      end
   end

   assign w_accept   = w_grant_vld;
   assign Req0_Ready = w_grant_vld && !w_grant_id;
   assign Req1_Ready = w_grant_vld &&  w_grant_id;

   assign w_sel_a  = w_grant_id ? Req1_A  : Req0_A;
   assign w_sel_b  = w_grant_id ? Req1_B  : Req0_B;
   assign w_sel_op = w_grant_id ? Req1_Op : Req0_Op;

`ifdef ALU_ILLEGAL_OP_EN
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      logic ok;
      ok = 1'b0;
      if (op == OP_W'(4'b0000) || op == OP_W'(4'b0001) || op == OP_W'(4'b0010) ||
          op == OP_W'(4'b0011) || op == OP_W'(4'b0100) || op == OP_W'(4'b1000) ||
          op == OP_W'(4'b1001) || op == OP_W'(4'b1010) || op == OP_W'(4'b1100) ||
          op == OP_W'(4'b1101))
         ok = 1'b1;
      return ok;
   endfunction

   assign w_illegal = !op_legal(w_sel_op);
`else
   assign w_illegal = 1'b0;
`endif

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next_state = w_illegal ? S_RESP : S_EXEC;
         end
         S_EXEC: begin
            if (r_cnt == '0)
               w_next_state = S_RESP;
         end
         S_RESP: begin
            if (Resp_Valid && Resp_Ready)
               w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Operand launch, execution counter and response capture
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Alu_A        <= '0;
         Alu_B        <= '0;
         Alu_Op       <= '0;
         Resp_Valid   <= 1'b0;
         Resp_Id      <= 1'b0;
         Resp_Out     <= '0;
         Resp_Zero    <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
         Resp_Err     <= 1'b0;
`endif
      end else begin
         r_busy <= (w_next_state != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  Alu_A        <= w_sel_a;
                  Alu_B        <= w_sel_b;
                  Alu_Op       <= w_illegal ? '0 : w_sel_op;
                  Resp_Id      <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_cnt        <= CNT_LOAD;
`ifdef ALU_ILLEGAL_OP_EN
                  // Illegal op answers directly without touching the ALU
                  if (w_illegal) begin
                     Resp_Out   <= '0;
                     Resp_Zero  <= 1'b0;
                     Resp_Err   <= 1'b1;
                     Resp_Valid <= 1'b1;
                  end
`endif
               end
            end
            S_EXEC: begin
               if (r_cnt == '0) begin
                  Resp_Out   <= Alu_Out;
                  Resp_Zero  <= Alu_Zero;
                  Resp_Valid <= 1'b1;
`ifdef ALU_ILLEGAL_OP_EN
                  Resp_Err   <= 1'b0;
`endif
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_RESP: begin
               if (Resp_Valid && Resp_Ready)
                  Resp_Valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifndef ALU_ILLEGAL_OP_EN
   assign Resp_Err = 1'b0;
`endif

   assign Busy = r_busy;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_share_ctrl
//  Scoreboard bench for alu_share_ctrl with a behavioural ALU attached.
//  Expected responses are queued when a request is accepted and compared when
//  the response handshake completes. Honours ALU_ILLEGAL_OP_EN.
// ----------------------------------------------------------------------------
module tb_alu_share_ctrl;

   localparam int unsigned W  = 32;
   localparam int unsigned OW = 4;

   typedef struct packed {
      logic          id;
      logic [W-1:0]  out;
      logic          zero;
      logic          err;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          r0_vld, r1_vld;
   logic [W-1:0]  r0_a, r0_b, r1_a, r1_b;
   logic [OW-1:0] r0_op, r1_op;
   logic          Req0_Ready, Req1_Ready;
   logic [W-1:0]  Alu_A, Alu_B, Alu_Out;
   logic [OW-1:0] Alu_Op;
   logic          Alu_Zero;
   logic          Resp_Valid, Resp_Id, Resp_Zero, Resp_Err, Busy;
   logic [W-1:0]  Resp_Out;
   logic          resp_rdy;

   int   n_total = 0;
   int   n_bad   = 0;
   exp_t sb_q[$];
   logic gnt_q[$];

   alu_share_ctrl dut (
      .Clk        (clk),
      .Reset      (rst),
      .Req0_Valid (r0_vld),
      .Req0_A     (r0_a),
      .Req0_B     (r0_b),
      .Req0_Op    (r0_op),
      .Req0_Ready (Req0_Ready),
      .Req1_Valid (r1_vld),
      .Req1_A     (r1_a),
      .Req1_B     (r1_b),
      .Req1_Op    (r1_op),
      .Req1_Ready (Req1_Ready),
      .Alu_A      (Alu_A),
      .Alu_B      (Alu_B),
      .Alu_Op     (Alu_Op),
      .Alu_Out    (Alu_Out),
      .Alu_Zero   (Alu_Zero),
      .Resp_Valid (Resp_Valid),
      .Resp_Id    (Resp_Id),
      .Resp_Out   (Resp_Out),
      .Resp_Zero  (Resp_Zero),
      .Resp_Err   (Resp_Err),
      .Resp_Ready (resp_rdy),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OW-1:0] op);
      case (op)
         4'b0000: return a + b;
         4'b0001: return a - b;
         4'b0010: return a & b;
         4'b0011: return a | b;
         4'b0100: return a ^ b;
         4'b1000: return a << b[4:0];
         4'b1001: return a >> b[4:0];
         4'b1010: return W'($signed(a) >>> b[4:0]);
         4'b1100: return {31'b0, ($signed(a) < $signed(b))};
         4'b1101: return {31'b0, (a < b)};
         default: return a + b + 32'd1;
      endcase
   endfunction

   assign Alu_Out  = alu_f(Alu_A, Alu_B, Alu_Op);
   assign Alu_Zero = (Alu_Out == '0);

   function automatic logic legal_op(input logic [OW-1:0] op);
      return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                        4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101};
   endfunction

   function automatic exp_t exp_of(input logic id, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [OW-1:0] op);
      exp_t e;
      e.id   = id;
      e.out  = alu_f(a, b, op);
      e.zero = (e.out == '0);
      e.err  = 1'b0;
`ifdef ALU_ILLEGAL_OP_EN
      if (!legal_op(op)) begin
         e.out  = '0;
         e.zero = 1'b0;
         e.err  = 1'b1;
      end
`endif
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on response handshake
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (r0_vld && Req0_Ready) begin
            sb_q.push_back(exp_of(1'b0, r0_a, r0_b, r0_op));
            gnt_q.push_back(1'b0);
         end
         if (r1_vld && Req1_Ready) begin
            sb_q.push_back(exp_of(1'b1, r1_a, r1_b, r1_op));
            gnt_q.push_back(1'b1);
         end
         if (Resp_Valid && resp_rdy) begin
            if (sb_q.size() == 0) begin
               check("resp_unexpected", 32'(Resp_Valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("resp_id",   32'(Resp_Id),   32'(e.id));
               check("resp_out",  Resp_Out,       e.out);
               check("resp_zero", 32'(Resp_Zero), 32'(e.zero));
               check("resp_err",  32'(Resp_Err),  32'(e.err));
            end
         end
      end
   end

   task automatic do_reset();
      rst    = 1'b1;
      r0_vld = 1'b0;
      r1_vld = 1'b0;
      sb_q.delete();
      gnt_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [OW-1:0] op);
      logic got;
      got = 1'b0;
      @(posedge clk); #1;
      if (id) begin r1_vld = 1'b1; r1_a = a; r1_b = b; r1_op = op; end
      else    begin r0_vld = 1'b1; r0_a = a; r0_b = b; r0_op = op; end
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if ((id && Req1_Ready) || (!id && Req0_Ready)) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_timeout", 32'(got), 32'd1);
      @(posedge clk); #1;
      if (id) r1_vld = 1'b0;
      else    r0_vld = 1'b0;
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!Busy && !Resp_Valid) begin
            done = 1'b1;
            break;
         end
      end
      check("idle_timeout", 32'(done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [OW-1:0] op_tab [11];
      logic          g0, g1, g2;
      logic          seen;

      op_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000,
                 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0101};
      rst = 1'b1; resp_rdy = 1'b1;
      r0_vld = 1'b0; r0_a = '0; r0_b = '0; r0_op = '0;
      r1_vld = 1'b0; r1_a = '0; r1_b = '0; r1_op = '0;
      #1;
      check("rst_alu_a",   Alu_A, 32'd0);
      check("rst_alu_op",  32'(Alu_Op), 32'd0);
      check("rst_valid",   32'(Resp_Valid), 32'd0);
      check("rst_out",     Resp_Out, 32'd0);
      check("rst_err",     32'(Resp_Err), 32'd0);
      check("rst_busy",    32'(Busy), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // 1: single add, latency and operand hold
      @(posedge clk); #1;
      r0_vld = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 4'b0000;
      @(negedge clk);
      check("t1_rdy0", 32'(Req0_Ready), 32'd1);
      check("t1_rdy1", 32'(Req1_Ready), 32'd0);
      @(posedge clk); #1 r0_vld = 1'b0;
      @(negedge clk);
      check("t1_valid_c1", 32'(Resp_Valid), 32'd0);
      check("t1_busy_c1",  32'(Busy), 32'd1);
      @(negedge clk);
      check("t1_valid_c2", 32'(Resp_Valid), 32'd1);
      check("t1_out_c2",   Resp_Out, 32'd12);
      wait_idle();
      check("t1_hold_a",  Alu_A, 32'd5);
      check("t1_hold_b",  Alu_B, 32'd7);
      check("t1_hold_op", 32'(Alu_Op), 32'd0);

      // 2: subtract to zero on requester 1
      issue(1'b1, 32'd1000000, 32'd1000000, 4'b0001);
      wait_idle();

      // 3: both valid from reset, held: grants alternate 0,1,0
      do_reset();
      @(posedge clk); #1;
      r0_vld = 1'b1; r0_a = 32'd10; r0_b = 32'd3; r0_op = 4'b0001;
      r1_vld = 1'b1; r1_a = 32'hF0;  r1_b = 32'h3C; r1_op = 4'b0100;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (gnt_q.size() >= 3) begin seen = 1'b1; break; end
      end
      check("t3_three_grants", 32'(seen), 32'd1);
      @(posedge clk); #1;
      r0_vld = 1'b0; r1_vld = 1'b0;
      wait_idle();
      g0 = (gnt_q.size() > 0) ? gnt_q[0] : 1'bx;
      g1 = (gnt_q.size() > 1) ? gnt_q[1] : 1'bx;
      g2 = (gnt_q.size() > 2) ? gnt_q[2] : 1'bx;
      check("t3_grant0", 32'(g0), 32'd0);
      check("t3_grant1", 32'(g1), 32'd1);
      check("t3_grant2", 32'(g2), 32'd0);

      // 4: response back-pressure
      resp_rdy = 1'b0;
      issue(1'b0, 32'h0F0F, 32'h00FF, 4'b0010);
      r1_vld = 1'b1; r1_a = 32'd1; r1_b = 32'd2; r1_op = 4'b0000;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (Resp_Valid) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      check("t4_resp_seen", 32'(seen), 32'd1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         check("t4_valid", 32'(Resp_Valid), 32'd1);
         check("t4_out",   Resp_Out, 32'h000F);
         check("t4_id",    32'(Resp_Id), 32'd0);
         check("t4_busy",  32'(Busy), 32'd1);
         check("t4_rdy0",  32'(Req0_Ready), 32'd0);
         check("t4_rdy1",  32'(Req1_Ready), 32'd0);
      end
      @(posedge clk); #1;
      r1_vld = 1'b0; resp_rdy = 1'b1;
      wait_idle();

      // 5: reset during EXEC drops the op
      issue(1'b0, 32'h1234, 32'h0001, 4'b0000);
      rst = 1'b1;
      #1;
      check("t5_alu_a",  Alu_A, 32'd0);
      check("t5_alu_b",  Alu_B, 32'd0);
      check("t5_valid",  32'(Resp_Valid), 32'd0);
      check("t5_busy",   32'(Busy), 32'd0);
      check("t5_id",     32'(Resp_Id), 32'd0);
      sb_q.delete();
      gnt_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5_no_resp", 32'(Resp_Valid), 32'd0);
      end

      // 6: illegal opcode 0101
      @(posedge clk); #1;
      r0_vld = 1'b1; r0_a = 32'd3; r0_b = 32'd4; r0_op = 4'b0101;
      @(negedge clk);
      check("t6_rdy0", 32'(Req0_Ready), 32'd1);
      @(posedge clk); #1 r0_vld = 1'b0;
      @(negedge clk);
`ifdef ALU_ILLEGAL_OP_EN
      check("t6_valid_c1", 32'(Resp_Valid), 32'd1);
      check("t6_err",      32'(Resp_Err), 32'd1);
      check("t6_out",      Resp_Out, 32'd0);
`else
      check("t6_valid_c1", 32'(Resp_Valid), 32'd0);
      @(negedge clk);
      check("t6_valid_c2", 32'(Resp_Valid), 32'd1);
      check("t6_err",      32'(Resp_Err), 32'd0);
      check("t6_out",      Resp_Out, 32'd8);
`endif
      wait_idle();

      // Random mix of opcodes and requesters
      for (int i = 0; i < 16; i++) begin
         issue(1'($urandom_range(0, 1)), $urandom(), $urandom(),
               op_tab[$urandom_range(0, 10)]);
         wait_idle();
      end

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
